ps2_keymap_decoder: RTL and testbench
=====================================

PS2_KEYMAP_DECODER -- requirements
Module: ps2_keymap_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 4; number of decoded keys (1..32).
REQ-002 Parameter KEY_CODES, default {9'h023, 9'h01B, 9'h01C, 9'h01D}; packed 9*NUM_KEYS table; entry i = bits [9i+8:9i] = {extended flag, scan code}; default index 0 W (1D), 1 A (1C), 2 S (1B), 3 D (23).
REQ-003 Parameter PREFIX_TIMEOUT, default 1_000_000; cycles a prefix state waits for its next byte before abandoning the sequence.
REQ-004 Parameter REPEAT_EN, default 0; 1 enables internal auto-repeat press pulses.
REQ-005 Parameter REPEAT_DELAY, default 25_000_000; cycles from make to first repeat pulse.
REQ-006 Parameter REPEAT_PERIOD, default 5_000_000; cycles between subsequent repeat pulses.
REQ-007 CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 received_data  input  8  byte from PS/2 receiver, valid only when received_data_en=1.
REQ-010 received_data_en  input  1  single-cycle byte strobe, already in CLOCK_50 domain.
REQ-011 key_down  output  NUM_KEYS  level; bit i=1 while key i is held.
REQ-012 key_press  output  NUM_KEYS  one-cycle pulse per make event or repeat event of key i.
REQ-013 key_release  output  NUM_KEYS  one-cycle pulse per break event of key i.
REQ-014 last_code  output  9  {ext, code} of most recent completed make, matched or not.
REQ-015 seq_error  output  1  one-cycle pulse when a prefix sequence times out.

Function
REQ-016 Decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-017 IDLE: E0 -> EXT; F0 -> BRK; any other byte = make {0,byte}, stay IDLE.
REQ-018 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte = make {1,byte} -> IDLE.
REQ-019 BRK: any byte = break {0,byte} -> IDLE; EXT_BRK: any byte = break {1,byte} -> IDLE.
REQ-020 Bytes SHALL be consumed only on cycles with received_data_en=1; all other cycles hold state.
REQ-021 Timeout counter SHALL clear on every accepted byte and on entry to IDLE, count while in EXT/BRK/EXT_BRK, and at PREFIX_TIMEOUT force IDLE and pulse seq_error.
REQ-022 received_data_en on the timeout cycle: byte is processed normally, timeout ignored, counter cleared.
REQ-023 Make/break SHALL compare the full 9-bit code against every table entry in parallel; duplicate entries all respond.
REQ-024 Make of matched key i not down: key_down[i] and key_press[i] SHALL assert on the edge after the final byte's strobe (latency 1 cycle).
REQ-025 Make of key i already down (keyboard typematic): no key_press pulse, key_down unchanged, repeat timer not restarted.
REQ-026 Break of key i down: key_down[i] clears and key_release[i] pulses, latency 1 cycle; break of key not down: no pulse, no change.
REQ-027 last_code SHALL update on every completed make (latency 1), never on break.
REQ-028 REPEAT_EN=1: repeat target SHALL be the most recently made key that produced key_press; timer restarts at 0 on each such make.
REQ-029 Repeat: key_press[target] pulses when timer reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while key_down[target]=1.
REQ-030 Break of repeat target SHALL stop repeat; releasing other keys SHALL NOT affect it; no retargeting to still-held keys.
REQ-031 Repeat pulse and new make on same cycle: new make wins, its press pulse issued, timer restarts.
REQ-032 REPEAT_EN=0: repeat logic absent; key_press only from REQ-024.
REQ-033 Counter widths SHALL be $clog2 of their maximum+1; no counter wraps.

Reset
REQ-034 reset=1 SHALL immediately force FSM IDLE, all counters 0, key_down/key_press/key_release 0, last_code 9'h000, seq_error 0, repeat target invalid.
REQ-035 Reset mid-sequence discards the partial sequence; first byte after release is decoded from IDLE.

Verification
REQ-036 Bytes 1D, F0 1D -> key_press[0] pulse, key_down[0]=1 until break, key_release[0] pulse; last_code=9'h01D.
REQ-037 KEY_CODES entry {1,75}; bytes E0 75, E0 F0 75 -> press/release on that index; byte 75 alone -> no match, last_code=9'h075.
REQ-038 PREFIX_TIMEOUT=8; byte F0 then idle 8 cycles -> seq_error pulse, FSM IDLE; next 1C -> key_press[1].
REQ-039 REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=4; make 1B held 30 cycles -> presses at cycles 1, 11, 15, 19, 23, 27 only; break stops them.
REQ-040 Make 1D, make 1C, repeat 1D typematic, break 1D -> repeat continues on index 1 only; key_down=4'b0010.
REQ-041 Assert reset between E0 and F0 -> all outputs 0; subsequent 23 -> key_press[3] (non-extended).

Source files
------------

// File: rtl/ps2_keymap_decoder.sv
// PS/2 scan-code decoder: turns a byte stream (with E0/F0 prefixes) into
// per-key held levels, press/release pulses and optional auto-repeat.
module ps2_keymap_decoder #(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int                      PREFIX_TIMEOUT = 1_000_000,
  parameter bit                      REPEAT_EN      = 1'b0,
  parameter int                      REPEAT_DELAY   = 25_000_000,
  parameter int                      REPEAT_PERIOD  = 5_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [8:0]          last_code,
  output logic                seq_error
);

  localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q;
  logic               tmo_fire;
  logic               make_evt, brk_evt;
  logic [8:0]         code;
  logic [NUM_KEYS-1:0] match, press_new, release_new, rep_pulse;

  // Prefix state register.
  // NOTE: every register here is cleared by the asynchronous reset, so a
  // partial sequence can never survive a reset pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: classify each accepted byte as prefix, make or break.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    code     = 9'h000;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (received_data_en) begin
          if (received_data == 8'hE0)      state_d = S_EXT;
          else if (received_data == 8'hF0) state_d = S_BRK;
          else begin
            make_evt = 1'b1;
            code     = {1'b0, received_data};
          end
        end
      end
      S_EXT: begin
        if (received_data_en) begin
          if (received_data == 8'hF0)      state_d = S_EXT_BRK;
          else if (received_data != 8'hE0) begin
            make_evt = 1'b1;
            code     = {1'b1, received_data};
            state_d  = S_IDLE;
          end
        end else if (tmo_q == TMO_W'(PREFIX_TIMEOUT)) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_BRK, S_EXT_BRK: begin
        if (received_data_en) begin
          brk_evt = 1'b1;
          code    = {(state_q == S_EXT_BRK), received_data};
          state_d = S_IDLE;
        end else if (tmo_q == TMO_W'(PREFIX_TIMEOUT)) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prefix timeout counter: runs only while waiting inside a prefix state.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                                  tmo_q <= '0;
    else if (received_data_en || state_q == S_IDLE || tmo_fire) tmo_q <= '0;
    else                                                        tmo_q <= tmo_q + TMO_W'(1);
  end

  // Compare the completed code against every table entry in parallel.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) match[i] = (KEY_CODES[9*i +: 9] == code);
    press_new   = make_evt ? (match & ~key_down) : '0;
    release_new = brk_evt  ? (match &  key_down) : '0;
  end

  // Key state, event pulses, last make code and timeout pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
      last_code   <= 9'h000;
      seq_error   <= 1'b0;
    end else begin
      key_down    <= (key_down | press_new) & ~release_new;
      key_press   <= press_new | rep_pulse;
      key_release <= release_new;
      seq_error   <= tmo_fire;
      if (make_evt) last_code <= code;
    end
  end

  if (REPEAT_EN) begin : g_repeat
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic          valid_q, phase_q, fire, tgt_break;
    logic [TW-1:0] tgt_q, new_tgt;
    logic [RW-1:0] cnt_q, cnt_nxt;

    // Pick the new repeat target (lowest newly pressed index) and decide firing.
    always_comb begin
      new_tgt = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) if (press_new[i]) new_tgt = TW'(i);
      cnt_nxt   = cnt_q + RW'(1);
      tgt_break = valid_q && release_new[tgt_q];
      fire      = valid_q && !(|press_new) && !tgt_break &&
                  (phase_q ? (cnt_nxt == RW'(REPEAT_PERIOD)) : (cnt_nxt == RW'(REPEAT_DELAY)));
      rep_pulse = fire ? (NUM_KEYS'(1) << tgt_q) : '0;
    end

    // Repeat timer: restarts on a fresh press, stops on release of the target.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        phase_q <= 1'b0;
        tgt_q   <= '0;
        cnt_q   <= '0;
      end else if (|press_new) begin
        valid_q <= 1'b1;
        phase_q <= 1'b0;
        tgt_q   <= new_tgt;
        cnt_q   <= '0;
      end else if (tgt_break) begin
        valid_q <= 1'b0;
        phase_q <= 1'b0;
        cnt_q   <= '0;
      end else if (valid_q) begin
        if (fire) begin
          phase_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q   <= cnt_nxt;
        end
      end
    end
  end else begin : g_no_repeat
    assign rep_pulse = '0;
  end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Randomised and directed bench for ps2_keymap_decoder; two instances share
// stimulus, one without and one with auto-repeat.
module tb_ps2_keymap_decoder;

  localparam int              NK     = 5;
  localparam logic [9*NK-1:0] CODES  = {9'h175, 9'h023, 9'h01B, 9'h01C, 9'h01D};
  localparam int              TMO    = 8;
  localparam int              RDLY   = 10;
  localparam int              RPER   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_en;
  logic [NK-1:0] down_a, press_a, rel_a, down_b, press_b, rel_b;
  logic [8:0]    last_a, last_b;
  logic          seq_a, seq_b;

  int tests = 0;
  int fails = 0;

  // Reference model state (abstract: prefix flags, elapsed-time repeat).
  logic [8:0]    tbl [NK] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175};
  bit            m_ext, m_brk, m_seq, m_rv;
  int            m_age, m_rt, m_rtime;
  logic [NK-1:0] m_down, m_rel, m_press_a, m_press_b;
  logic [8:0]    m_last;

  always #5 clk = ~clk;

  ps2_keymap_decoder #(
    .NUM_KEYS(NK), .KEY_CODES(CODES), .PREFIX_TIMEOUT(TMO),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .received_data(rx_data), .received_data_en(rx_en),
    .key_down(down_a), .key_press(press_a), .key_release(rel_a),
    .last_code(last_a), .seq_error(seq_a)
  );

  ps2_keymap_decoder #(
    .NUM_KEYS(NK), .KEY_CODES(CODES), .PREFIX_TIMEOUT(TMO),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .received_data(rx_data), .received_data_en(rx_en),
    .key_down(down_b), .key_press(press_b), .key_release(rel_b),
    .last_code(last_b), .seq_error(seq_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_seq = 0; m_rv = 0;
    m_age = 0; m_rt = 0; m_rtime = 0;
    m_down = '0; m_rel = '0; m_press_a = '0; m_press_b = '0; m_last = 9'h000;
  endtask

  // Predict the outputs visible after the coming clock edge.
  task automatic model_step(input bit en, input logic [7:0] d);
    bit            mk = 0, bk = 0;
    logic [8:0]    c = 9'h000;
    logic [NK-1:0] hit, newp;
    m_seq = 0;
    if (en) begin
      m_age = 0;
      if (m_brk) begin
        bk = 1; c = {m_ext, d}; m_ext = 0; m_brk = 0;
      end else if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0)     m_brk = 1;
      else begin
        mk = 1; c = {m_ext, d}; m_ext = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_age == TMO) begin
        m_ext = 0; m_brk = 0; m_age = 0; m_seq = 1;
      end else m_age++;
    end
    for (int i = 0; i < NK; i++) hit[i] = (c == tbl[i]);
    newp   = mk ? (hit & ~m_down) : '0;
    m_rel  = bk ? (hit &  m_down) : '0;
    m_down = (m_down | newp) & ~m_rel;
    if (mk) m_last = c;
    m_press_a = newp;
    m_press_b = newp;
    if (newp != '0) begin
      m_rv = 1; m_rtime = 0;
      for (int i = NK - 1; i >= 0; i--) if (newp[i]) m_rt = i;
    end else if (m_rv && m_rel[m_rt]) begin
      m_rv = 0;
    end else if (m_rv) begin
      m_rtime++;
      if (m_rtime >= RDLY && (m_rtime - RDLY) % RPER == 0) m_press_b[m_rt] = 1'b1;
    end
  endtask

  // One clock cycle: drive, predict, then compare just after the edge.
  task automatic step(input bit en, input logic [7:0] d);
    @(negedge clk);
    rx_en = en; rx_data = d;
    model_step(en, d);
    @(posedge clk); #1;
    check("down_a",  16'(down_a),  16'(m_down));
    check("press_a", 16'(press_a), 16'(m_press_a));
    check("rel_a",   16'(rel_a),   16'(m_rel));
    check("last_a",  16'(last_a),  16'(m_last));
    check("seq_a",   16'(seq_a),   16'(m_seq));
    check("down_b",  16'(down_b),  16'(m_down));
    check("press_b", 16'(press_b), 16'(m_press_b));
    check("rel_b",   16'(rel_b),   16'(m_rel));
    check("last_b",  16'(last_b),  16'(m_last));
    check("seq_b",   16'(seq_b),   16'(m_seq));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_en = 1'b0; rx_data = 8'h00;
    #1;
    check("rst_down",  16'({down_a, down_b}),   16'h0);
    check("rst_press", 16'({press_a, press_b}), 16'h0);
    check("rst_rel",   16'({rel_a, rel_b}),     16'h0);
    check("rst_last",  16'(last_a | last_b),    16'h0);
    check("rst_seq",   16'({seq_a, seq_b}),     16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h00};
    int cnt, cnt0;
    reset = 1'b1; rx_en = 1'b0; rx_data = 8'h00;
    model_reset();
    do_reset();

    // Plain make and break of W.
    step(1, 8'h1D);
    check("w_press", 16'(press_a[0]), 16'h1);
    check("w_last",  16'(last_a),     16'h01D);
    step(0, 8'h00);
    check("w_held",  16'(down_a[0]),  16'h1);
    step(1, 8'hF0); step(1, 8'h1D);
    check("w_rel",   16'(rel_a[0]),   16'h1);
    check("w_up",    16'(down_a[0]),  16'h0);

    // Extended key, and the same code without E0 must not match.
    step(1, 8'hE0); step(1, 8'h75);
    check("x_press", 16'(press_a[4]), 16'h1);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75);
    check("x_rel",   16'(rel_a[4]),   16'h1);
    step(1, 8'h75);
    check("x_nomat", 16'(press_a),    16'h0);
    check("x_last",  16'(last_a),     16'h075);

    // Prefix timeout, then a fresh make decodes from idle.
    do_reset();
    step(1, 8'hF0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00);
      if (seq_a) cnt++;
    end
    check("tmo_cnt", 16'(cnt), 16'h1);
    step(1, 8'h1C);
    check("tmo_next", 16'(press_a[1]), 16'h1);

    // Auto-repeat timing on S.
    do_reset();
    step(1, 8'h1B);
    check("rep_c1", 16'(press_b[2]), 16'h1);
    for (int c = 2; c <= 30; c++) begin
      step(0, 8'h00);
      check("rep_cyc", 16'(press_b[2]), 16'(c inside {11, 15, 19, 23, 27}));
    end
    step(1, 8'hF0); step(1, 8'h1B);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00);
      if (press_b != '0) cnt++;
    end
    check("rep_stop", 16'(cnt), 16'h0);

    // Repeat target survives release of another key.
    do_reset();
    step(1, 8'h1D); step(1, 8'h1C);
    step(1, 8'h1D);
    check("typ_nopress", 16'(press_b), 16'h0);
    step(1, 8'hF0); step(1, 8'h1D);
    cnt = 0; cnt0 = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 8'h00);
      if (press_b[1]) cnt++;
      if (press_b[0]) cnt0++;
    end
    check("tgt_rep1", 16'(cnt > 0), 16'h1);
    check("tgt_rep0", 16'(cnt0),    16'h0);
    check("tgt_down", 16'(down_b),  16'b00010);

    // Reset mid-sequence discards the E0 prefix.
    step(1, 8'hE0);
    do_reset();
    step(1, 8'h23);
    check("rst_seq_press", 16'(press_a[3]), 16'h1);
    check("rst_seq_last",  16'(last_a),     16'h023);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      if ($urandom_range(0, 799) == 0) do_reset();
      else step($urandom_range(0, 5) == 0, (sel == 7) ? 8'($urandom) : pool[sel]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
